win_mean_filt: RTL and testbench
================================

Name: win_mean_filt

Overview:
- Consumer end of the sliding-window interface. Accepts one KSZ×KSZ pixel window per valid cycle from the window buffer and emits one mean-filtered pixel per window as a raster stream.
- Border windows pass the original centre pixel through unfiltered.
- Sits between the window buffer and downstream ISP stages. Also counts output pixels per frame and flags frames whose pixel count is wrong.

Parameters:
- DW, 14, pixel bit width
- KSZ, 3, window side; must be odd, ≥3
- IH, 512, image height in lines
- IW, 640, image width in pixels
- SHIFT, 16, fixed-point shift used for the reciprocal
- localparam NUM = KSZ*KSZ
- localparam RECIP = (2^SHIFT + NUM/2) / NUM, integer. KSZ=3 gives 7282.

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, synchronous active-low reset
- din_valid, input, 1, window vector valid
- din, input, DW*NUM, window vector. Element i = row*KSZ+col occupies din[(i+1)*DW-1 : i*DW].
- din_org, input, DW, centre pixel; equals element NUM/2
- vsync, input, 1, frame active (high during frame), aligned with din
- is_boarder, input, 1, window overlaps image border; qualified by din_valid
- dout, output, DW, filtered pixel
- dout_valid, output, 1, dout valid
- vsync_out, output, 1, vsync delayed to match dout
- frame_done, output, 1, one-cycle pulse at end of each output frame
- cnt_err, output, 1, sticky: the last frame's pixel count was not IH*IW

Behaviour:
- One clock. Reset is synchronous, active-low, sampled on the clk rising edge.
- On reset, all outputs are 0: dout, dout_valid, vsync_out, frame_done, cnt_err. All pipeline registers and the pixel counter are cleared.
- Pipeline is 3 stages, fixed latency 3 cycles from din_valid to dout_valid. There is no backpressure; one window can be accepted every cycle.
- S1, when din_valid:
  - KSZ row sums, each DW+clog2(KSZ) bits wide.
  - Register din_org and is_boarder.
- S2: total sum = sum of the row sums, width DW+clog2(NUM).
- S3:
  - mean = (sum*RECIP + 2^(SHIFT-1)) >> SHIFT.
  - Saturate to 2^DW-1. With DW=14 the product fits in 32 bits.
  - If the delayed is_boarder is 1, dout = delayed din_org; else dout = mean.
- Each stage's data register loads only when that stage's valid is 1, so dout holds its last value while dout_valid is 0.
- Stage valids are a 3-deep shift of din_valid. vsync passes through an identical 3-deep shift register, independent of din_valid.
- Pixel counter:
  - Width clog2(IH*IW+1).
  - Increments on each dout_valid, saturating at its maximum.
- On a falling edge of vsync_out (registered previous value = 1, current = 0):
  - frame_done = 1 for exactly one cycle.
  - cnt_err ← (count != IH*IW).
  - Count returns to 0 in the same cycle. A dout_valid in that same cycle counts as 1 toward the next frame.
- A rising edge of vsync_out has no effect on the counter.
- cnt_err holds until the next frame_done or reset.
- Reset mid-frame: in-flight windows are discarded with no output. The counter clears and no frame_done is generated for the aborted frame.
- din_valid while vsync is low is still filtered and output, and it is counted into the next frame.

Test Plan:
- Reset: hold rst_n=0 for 4 cycles with din_valid=1 -> all outputs 0. Release: the first dout_valid appears exactly 3 cycles after the first valid window.
- Uniform window: KSZ=3, DW=8, all elements 100, is_boarder=0 -> dout=100. All elements 255 -> dout=255 with no overflow.
- Mixed values: elements 0..8, sum 36, is_boarder=0 -> dout=4. Elements {9×16383} at DW=14 -> dout=16383 (saturation boundary).
- Border passthrough: elements all 50, din_org=200, is_boarder=1 -> dout=200. The next window, with is_boarder=0, gives dout=50.
- Back-to-back and gapped valid: alternate din_valid 1/0 for 10 cycles -> dout_valid repeats the same pattern shifted by 3 cycles, and dout holds its value during gaps.
- Frame accounting: IH=4, IW=4, vsync high for 16 valid windows then low -> frame_done pulses once 3 cycles after vsync falls, cnt_err=0. Next frame with 15 windows -> cnt_err=1. Reset mid-frame -> no frame_done and count=0.

Source files
------------

// File: rtl/win_mean_filt.sv
// Sliding-window mean filter: sums a KSZ x KSZ window, scales it by a fixed-point reciprocal
// and passes the centre pixel through on border windows. It also checks the output pixel count per frame.
module win_mean_filt #(
    parameter int DW    = 14,
    parameter int KSZ   = 3,
    parameter int IH    = 512,
    parameter int IW    = 640,
    parameter int SHIFT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_valid,
    input  logic [DW*KSZ*KSZ-1:0] din,
    input  logic [DW-1:0]         din_org,
    input  logic                  vsync,
    input  logic                  is_boarder,
    output logic [DW-1:0]         dout,
    output logic                  dout_valid,
    output logic                  vsync_out,
    output logic                  frame_done,
    output logic                  cnt_err
);
    localparam int NUM   = KSZ * KSZ;
    localparam int RECIP = ((1 << SHIFT) + NUM / 2) / NUM;
    localparam int RW    = DW + $clog2(KSZ);
    localparam int SW    = DW + $clog2(NUM);
    localparam int PW    = SW + SHIFT + 1;
    localparam int FRAME = IH * IW;
    localparam int CW    = $clog2(FRAME + 1);
    localparam logic [DW-1:0] PMAX = '1;

    logic [KSZ-1:0][RW-1:0] row_sum, row_d, row_q;
    logic [DW-1:0]          org1_d, org1_q, org2_d, org2_q;
    logic                   brd1_d, brd1_q, brd2_d, brd2_q;
    logic [SW-1:0]          sum_acc, sum_d, sum_q;
    logic [PW-1:0]          prod, mean_w;
    logic [DW-1:0]          mean, dout_d, dout_q;
    logic [2:0]             vld_d, vld_q, vs_d, vs_q;
    logic [CW-1:0]          cnt_inc, cnt_d, cnt_q;
    logic                   fall, frame_done_d, frame_done_q, cnt_err_d, cnt_err_q;

    // S1: row sums
    always_comb begin
        for (int r = 0; r < KSZ; r++) begin
            row_sum[r] = '0;
            for (int c = 0; c < KSZ; c++)
                row_sum[r] = row_sum[r] + RW'(din[(r*KSZ+c)*DW +: DW]);
        end
        row_d  = din_valid ? row_sum    : row_q;
        org1_d = din_valid ? din_org    : org1_q;
        brd1_d = din_valid ? is_boarder : brd1_q;
    end

    // S2: total sum
    always_comb begin
        sum_acc = '0;
        for (int r = 0; r < KSZ; r++)
            sum_acc = sum_acc + SW'(row_q[r]);
        sum_d  = vld_q[0] ? sum_acc : sum_q;
        org2_d = vld_q[0] ? org1_q  : org2_q;
        brd2_d = vld_q[0] ? brd1_q  : brd2_q;
    end

    // S3: rounded reciprocal multiply, saturate, border mux
    always_comb begin
        prod   = PW'(sum_q) * PW'(RECIP) + (PW'(1) << (SHIFT - 1));
        mean_w = prod >> SHIFT;
        mean   = (mean_w > PW'(PMAX)) ? PMAX : mean_w[DW-1:0];
        dout_d = dout_q;
        if (vld_q[1])
            dout_d = brd2_q ? org2_q : mean;
    end

    // vs_q[1] is the next value of vsync_out, so the fall is seen one edge early and
    // frame_done/cnt_err are registered in the same cycle vsync_out drops.
    always_comb begin
        vld_d        = {vld_q[1:0], din_valid};
        vs_d         = {vs_q[1:0], vsync};
        fall         = vs_q[2] & ~vs_q[1];
        cnt_inc      = (vld_q[2] && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
        cnt_d        = cnt_inc;
        cnt_err_d    = cnt_err_q;
        frame_done_d = 1'b0;
        if (fall) begin
            frame_done_d = 1'b1;
            cnt_err_d    = (cnt_inc != CW'(FRAME));
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q        <= '0;
            org1_q       <= '0;
            brd1_q       <= 1'b0;
            sum_q        <= '0;
            org2_q       <= '0;
            brd2_q       <= 1'b0;
            dout_q       <= '0;
            vld_q        <= '0;
            vs_q         <= '0;
            cnt_q        <= '0;
            cnt_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            org1_q       <= org1_d;
            brd1_q       <= brd1_d;
            sum_q        <= sum_d;
            org2_q       <= org2_d;
            brd2_q       <= brd2_d;
            dout_q       <= dout_d;
            vld_q        <= vld_d;
            vs_q         <= vs_d;
            cnt_q        <= cnt_d;
            cnt_err_q    <= cnt_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q[2];
    assign vsync_out  = vs_q[2];
    assign frame_done = frame_done_q;
    assign cnt_err    = cnt_err_q;
endmodule

// File: tb/tb_win_mean_filt.sv
// Directed bench for win_mean_filt: latency, mean rounding, border passthrough,
// gapped valids and per-frame pixel accounting on a 4x4 image.
module tb_win_mean_filt;
    localparam int DW    = 14;
    localparam int KSZ   = 3;
    localparam int IH    = 4;
    localparam int IW    = 4;
    localparam int SHIFT = 16;
    localparam int NUM   = KSZ * KSZ;
    localparam int DIN_W = DW * NUM;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             din_valid;
    logic [DIN_W-1:0] din;
    logic [DW-1:0]    din_org;
    logic             vsync;
    logic             is_boarder;
    logic [DW-1:0]    dout;
    logic             dout_valid;
    logic             vsync_out;
    logic             frame_done;
    logic             cnt_err;

    int total = 0;
    int bad   = 0;

    win_mean_filt #(.DW(DW), .KSZ(KSZ), .IH(IH), .IW(IW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .din_org(din_org),
        .vsync(vsync), .is_boarder(is_boarder), .dout(dout), .dout_valid(dout_valid),
        .vsync_out(vsync_out), .frame_done(frame_done), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIN_W-1:0] uni(input int v);
        logic [DIN_W-1:0] r;
        for (int i = 0; i < NUM; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [DIN_W-1:0] ramp();
        logic [DIN_W-1:0] r;
        for (int i = 0; i < NUM; i++) r[i*DW +: DW] = DW'(i);
        return r;
    endfunction

    function automatic logic [DIN_W-1:0] spike(input int v);
        logic [DIN_W-1:0] r;
        for (int i = 0; i < NUM; i++) r[i*DW +: DW] = (i == NUM / 2) ? DW'(v) : '0;
        return r;
    endfunction

    task automatic test_reset();
        logic [DW+3:0] o;
        rst_n = 1'b0; din_valid = 1'b1; din = uni(100); din_org = 14'd100;
        vsync = 1'b0; is_boarder = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            o = {dout, dout_valid, vsync_out, frame_done, cnt_err};
            total++;
            if (o !== '0) begin bad++; $display("FAIL reset_zero cyc%0d got=%h want=0", k, o); end
        end
        rst_n = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            total++;
            if (dout_valid !== (k == 3)) begin
                bad++; $display("FAIL first_latency edge%0d got=%b want=%b", k, dout_valid, k == 3);
            end
            if (k < 3) tick();
        end
        total++;
        if (dout !== 14'd100) begin bad++; $display("FAIL first_dout got=%0d want=100", dout); end
        tick();
        total++;
        if (dout_valid !== 1'b0 || dout !== 14'd100) begin
            bad++; $display("FAIL first_hold got=%b/%0d want=0/100", dout_valid, dout);
        end
        tick();
    endtask

    task automatic test_uniform();
        din_valid = 1'b1; din = uni(100); din_org = 14'd100; tick();
        din = uni(255); din_org = 14'd255; tick();
        din_valid = 1'b0; tick();
        total++;
        if (dout_valid !== 1'b1 || dout !== 14'd100) begin
            bad++; $display("FAIL uniform_100 got=%b/%0d want=1/100", dout_valid, dout);
        end
        tick();
        total++;
        if (dout_valid !== 1'b1 || dout !== 14'd255) begin
            bad++; $display("FAIL uniform_255 got=%b/%0d want=1/255", dout_valid, dout);
        end
        repeat (2) tick();
    endtask

    task automatic test_mixed();
        din_valid = 1'b1; din = ramp(); din_org = 14'd4; tick();
        din = uni(16383); din_org = 14'd16383; tick();
        din = spike(90); din_org = 14'd90; tick();
        din_valid = 1'b0;
        total++;
        if (dout !== 14'd4) begin bad++; $display("FAIL ramp_mean got=%0d want=4", dout); end
        tick();
        total++;
        if (dout !== 14'd16383) begin bad++; $display("FAIL max_mean got=%0d want=16383", dout); end
        tick();
        total++;
        if (dout !== 14'd10) begin bad++; $display("FAIL spike_mean got=%0d want=10", dout); end
        repeat (2) tick();
    endtask

    task automatic test_border();
        din_valid = 1'b1; din = uni(50); din_org = 14'd200; is_boarder = 1'b1; tick();
        din_org = 14'd50; is_boarder = 1'b0; tick();
        din_valid = 1'b0; tick();
        total++;
        if (dout !== 14'd200) begin bad++; $display("FAIL border_pass got=%0d want=200", dout); end
        tick();
        total++;
        if (dout !== 14'd50) begin bad++; $display("FAIL border_next got=%0d want=50", dout); end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic vin [14];
        int   vv  [14];
        int   last = 50;
        for (int t = 0; t < 14; t++) begin
            vin[t] = (t < 10) && (t % 2 == 0);
            vv[t]  = 10 * (t + 1);
            din_valid = vin[t]; din = uni(vv[t]); din_org = DW'(vv[t]);
            tick();
            if (t >= 2) begin
                if (vin[t-2]) last = vv[t-2];
                total++;
                if (dout_valid !== vin[t-2] || dout !== DW'(last)) begin
                    bad++;
                    $display("FAIL gapped step%0d got=%b/%0d want=%b/%0d", t, dout_valid, dout, vin[t-2], last);
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_frame();
        int n   [3] = '{16, 15, 16};
        logic e [3] = '{1'b0, 1'b1, 1'b0};
        int pulses, at, dv;
        rst_n = 1'b0; din_valid = 1'b0; vsync = 1'b0; tick();
        rst_n = 1'b1; tick();
        total++;
        if (cnt_err !== 1'b0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL frame_init got=%b/%b want=0/0", cnt_err, frame_done);
        end
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                total++;
                if (cnt_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", cnt_err); end
                vsync = 1'b1; din_valid = 1'b1; din = uni(7); din_org = 14'd7;
                repeat (8) tick();
                rst_n = 1'b0; din_valid = 1'b0; vsync = 1'b0; tick();
                rst_n = 1'b1;
                pulses = 0; dv = 0;
                for (int k = 0; k < 8; k++) begin
                    tick();
                    if (frame_done) pulses++;
                    if (dout_valid) dv++;
                end
                total++;
                if (pulses != 0 || dv != 0 || cnt_err !== 1'b0) begin
                    bad++; $display("FAIL abort got=%0d/%0d/%b want=0/0/0", pulses, dv, cnt_err);
                end
            end
            vsync = 1'b1; din_valid = 1'b1; din = uni(f + 1); din_org = DW'(f + 1);
            repeat (n[f]) tick();
            vsync = 1'b0; din_valid = 1'b0;
            pulses = 0; at = -1;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (frame_done) begin pulses++; if (at < 0) at = k; end
            end
            total++;
            if (pulses != 1 || at != 3) begin
                bad++; $display("FAIL frame%0d_done got=%0d@%0d want=1@3", f, pulses, at);
            end
            total++;
            if (cnt_err !== e[f] || vsync_out !== 1'b0) begin
                bad++; $display("FAIL frame%0d_err got=%b/%b want=%b/0", f, cnt_err, vsync_out, e[f]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_mixed();
        test_border();
        test_back_to_back();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
